ped_xing_ctrl: RTL

// Parametrised pedestrian-crossing controller: one traffic head (R/Y/G), one pedestrian head
// (R/G) and a request "wait" lamp. Timings are parameters counted in ticks of a 1-cycle enable.

---
 rtl/ped_xing_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl
// Pedestrian-crossing controller. It drives one traffic head (R/Y/G), one
// pedestrian head (R/G) and a "wait" lamp that shows a pending request.
// Phase lengths are counted in ticks of a one-cycle timebase enable.
// The controller enforces a minimum green, an all-red clearance before the
// walk phase, and a blinking walk phase. A night mode flashes the traffic
// yellow lamp.
//
// Ports
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous reset, active low
//   tick          in   1      one-cycle timebase enable
//   btn           in   1      debounced pedestrian button (level)
//   night_mode    in   1      request flashing-yellow operation
//   traff_red     out  1      traffic red lamp
//   traff_yellow  out  1      traffic yellow lamp
//   traff_green   out  1      traffic green lamp
//   ped_red       out  1      pedestrian red lamp
//   ped_green     out  1      pedestrian green lamp
//   wait_lamp     out  1      pedestrian request pending
//   state_o       out  3      current state code
//   timer_o       out  CNT_W  remaining ticks in the phase, minus 1
module ped_xing_ctrl #(
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 60,
    parameter int T_YELLOW    = 4,
    parameter int T_ALL_RED   = 2,
    parameter int T_PED_GREEN = 25,
    parameter int T_PED_BLINK = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             btn,
    input  logic             night_mode,
    output logic             traff_red,
    output logic             traff_yellow,
    output logic             traff_green,
    output logic             ped_red,
    output logic             ped_green,
    output logic             wait_lamp,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] timer_o
);

    typedef enum logic [2:0] {
        S_GREEN      = 3'd0,
        S_GREEN_WAIT = 3'd1,
        S_YELLOW     = 3'd2,
        S_ALL_RED    = 3'd3,
        S_PED_GREEN  = 3'd4,
        S_PED_BLINK  = 3'd5,
        S_NIGHT      = 3'd6
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             blink, blink_nx;
    logic             req, req_nx;
    logic             btn_prev;

    logic expire;
    logic btn_rise;
    logic in_walk_or_night;
    logic lamp_tr, lamp_ty, lamp_tg, lamp_pr, lamp_pg;

    assign expire           = tick && (timer == '0);
    assign btn_rise         = btn && !btn_prev;
    assign in_walk_or_night = (state == S_PED_GREEN) || (state == S_PED_BLINK) ||
                              (state == S_NIGHT);

    // Phase length minus one for the state that is being entered. States
    // without a timed phase (GREEN_WAIT, NIGHT) park the timer at zero.
    function automatic logic [CNT_W-1:0] load_value(input state_t s);
        case (s)
            S_GREEN:     load_value = CNT_W'(T_MIN_GREEN - 1);
            S_YELLOW:    load_value = CNT_W'(T_YELLOW - 1);
            S_ALL_RED:   load_value = CNT_W'(T_ALL_RED - 1);
            S_PED_GREEN: load_value = CNT_W'(T_PED_GREEN - 1);
            S_PED_BLINK: load_value = CNT_W'(T_PED_BLINK - 1);
            default:     load_value = '0;
        endcase
    endfunction

    // Next-state logic and the actions taken when a state is entered.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves one
        // unassigned. An unassigned path would infer a latch.
        state_nx = state;
        timer_nx = timer;
        blink_nx = blink;
        req_nx   = req;

        // The timer stops at zero instead of wrapping. In GREEN_WAIT and
        // NIGHT it sits at zero until the state is left.
        if (tick && (timer != '0))
            timer_nx = timer - 1'b1;

        if (tick && ((state == S_PED_BLINK) || (state == S_NIGHT)))
            blink_nx = ~blink;

        // A press is taken only on an edge outside the walk and night
        // phases. A button held through the walk phase therefore needs a
        // new edge before it counts again.
        if (btn_rise && !in_walk_or_night)
            req_nx = 1'b1;

        case (state)
            S_GREEN: begin
                if (night_mode)
                    state_nx = S_NIGHT;
                else if (expire)
                    state_nx = req ? S_YELLOW : S_GREEN_WAIT;
            end
            S_GREEN_WAIT: begin
                if (night_mode)
                    state_nx = S_NIGHT;
                else if (req)
                    state_nx = S_YELLOW;
            end
            S_YELLOW:    if (expire) state_nx = S_ALL_RED;
            S_ALL_RED:   if (expire) state_nx = S_PED_GREEN;
            S_PED_GREEN: if (expire) state_nx = S_PED_BLINK;
            S_PED_BLINK: if (expire) state_nx = S_GREEN;
            S_NIGHT:     if (!night_mode) state_nx = S_GREEN;
            default:     state_nx = S_GREEN;   // unused code 7 recovers
        endcase

        // No state moves to itself. A change of state therefore always
        // means that the new state is being entered.
        if (state_nx != state) begin
            timer_nx = load_value(state_nx);
            if ((state_nx == S_PED_GREEN) || (state_nx == S_NIGHT))
                req_nx = 1'b0;
            if ((state_nx == S_PED_BLINK) || (state_nx == S_NIGHT))
                blink_nx = 1'b0;
        end
    end

    // Lamp decode from the current state. It is registered below, so the
    // lamps follow the state one cycle later.
    always_comb begin
        lamp_tr = 1'b0;
        lamp_ty = 1'b0;
        lamp_tg = 1'b0;
        lamp_pr = 1'b0;
        lamp_pg = 1'b0;
        case (state)
            S_GREEN, S_GREEN_WAIT: begin lamp_tg = 1'b1; lamp_pr = 1'b1;    end
            S_YELLOW:              begin lamp_ty = 1'b1; lamp_pr = 1'b1;    end
            S_ALL_RED:             begin lamp_tr = 1'b1; lamp_pr = 1'b1;    end
            S_PED_GREEN:           begin lamp_tr = 1'b1; lamp_pg = 1'b1;    end
            S_PED_BLINK:           begin lamp_tr = 1'b1; lamp_pg = ~blink;  end
            S_NIGHT:               lamp_ty = ~blink;
            default:               begin lamp_tg = 1'b1; lamp_pr = 1'b1;    end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from the values they held before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_GREEN;
            timer    <= CNT_W'(T_MIN_GREEN - 1);
            blink    <= 1'b0;
            req      <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            blink    <= blink_nx;
            req      <= req_nx;
            btn_prev <= btn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            traff_red    <= 1'b0;
            traff_yellow <= 1'b0;
            traff_green  <= 1'b1;
            ped_red      <= 1'b1;
            ped_green    <= 1'b0;
        end else begin
            traff_red    <= lamp_tr;
            traff_yellow <= lamp_ty;
            traff_green  <= lamp_tg;
            ped_red      <= lamp_pr;
            ped_green    <= lamp_pg;
        end
    end

    assign wait_lamp = req;
    assign state_o   = state;
    assign timer_o   = timer;

endmodule
